// File: rtl/pc_redirect_unit.sv
// ============================================================================
// pc_redirect_unit : owns the fetch PC, arbitrates ID/EX/MEM redirects
//                    (oldest wins), emits flushes and the fetch-valid bubble.
// Optional stats counters enabled by macro PC_REDIRECT_STATS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_redirect_unit #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
`ifdef PC_REDIRECT_STATS_EN
  , parameter int unsigned   STAT_W   = 16
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            id_redirect,
  input  logic [PC_W-1:0] id_target,
  input  logic            ex_redirect,
  input  logic [PC_W-1:0] ex_target,
  input  logic            mem_redirect,
  input  logic [PC_W-1:0] mem_target,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc_plus1,
  output logic            if_valid,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            flush_exmem,
  output logic            redirect_taken
`ifdef PC_REDIRECT_STATS_EN
  , output logic [STAT_W-1:0] stat_mem
  , output logic [STAT_W-1:0] stat_ex
  , output logic [STAT_W-1:0] stat_id
`endif
);

  localparam logic [0:0]      S_RUN    = 1'b0;
  localparam logic [0:0]      S_REFILL = 1'b1;
  localparam logic [PC_W-1:0] c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_target;
  logic            w_take_mem;
  logic            w_take_ex;
  logic            w_take_id;
  logic            w_taken;

  // Priority select; every request is masked while reset is high.
  assign w_take_mem = ~reset & mem_redirect;
  assign w_take_ex  = ~reset & ~mem_redirect & ex_redirect;
  assign w_take_id  = ~reset & ~mem_redirect & ~ex_redirect & id_redirect;
  assign w_taken    = w_take_mem | w_take_ex | w_take_id;

  always_comb begin
    w_target = id_target;
    if (mem_redirect)     w_target = mem_target;
    else if (ex_redirect) w_target = ex_target;
  end

  assign flush_exmem    = w_take_mem;
  assign flush_idex     = w_take_mem | w_take_ex;
  assign flush_ifid     = w_taken;
  assign redirect_taken = w_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (w_taken) begin
      r_pc <= w_target;
    end else if (!stall) begin
      r_pc <= r_pc + c_PC_ONE;
    end
  end

  assign pc_out   = r_pc;
  assign pc_plus1 = r_pc + c_PC_ONE;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_REFILL;
    else       r_state <= w_state_nxt;
  end

  // REFILL lasts one cycle unless another redirect restarts it; stall never extends it.
  always_comb begin
    w_state_nxt = S_RUN;
    case (r_state)
      S_RUN:    if (w_taken) w_state_nxt = S_REFILL;
      S_REFILL: if (w_taken) w_state_nxt = S_REFILL;
      default:  w_state_nxt = S_REFILL;
    endcase
  end

  always_comb begin
    if_valid = 1'b0;
    case (r_state)
      S_RUN:    if_valid = 1'b1;
      default:  if_valid = 1'b0;
    endcase
  end

`ifdef PC_REDIRECT_STATS_EN
  localparam logic [STAT_W-1:0] c_STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  logic [STAT_W-1:0] r_stat_mem;
  logic [STAT_W-1:0] r_stat_ex;
  logic [STAT_W-1:0] r_stat_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_mem <= '0;
      r_stat_ex  <= '0;
      r_stat_id  <= '0;
    end else begin
      if (w_take_mem && (r_stat_mem != '1)) r_stat_mem <= r_stat_mem + c_STAT_ONE;
      if (w_take_ex  && (r_stat_ex  != '1)) r_stat_ex  <= r_stat_ex  + c_STAT_ONE;
      if (w_take_id  && (r_stat_id  != '1)) r_stat_id  <= r_stat_id  + c_STAT_ONE;
    end
  end

  assign stat_mem = r_stat_mem;
  assign stat_ex  = r_stat_ex;
  assign stat_id  = r_stat_id;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
// ============================================================================
// tb_pc_redirect_unit : directed vector table plus randomized run against a
//                       cycle-level reference model of the redirect rules.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_redirect_unit;

  localparam logic [15:0] RST_PC = 16'h0010;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic        id_redirect, ex_redirect, mem_redirect;
  logic [15:0] id_target, ex_target, mem_target;
  logic [15:0] pc_out, pc_plus1;
  logic        if_valid, flush_ifid, flush_idex, flush_exmem, redirect_taken;

  always #5 clk = ~clk;

  pc_redirect_unit #(.PC_W(16), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .id_redirect(id_redirect), .id_target(id_target),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .mem_redirect(mem_redirect), .mem_target(mem_target),
    .pc_out(pc_out), .pc_plus1(pc_plus1), .if_valid(if_valid),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .redirect_taken(redirect_taken)
  );

  typedef struct {
    logic        rst, stl, m, e, i;
    logic [15:0] mt, et, it;
    logic [15:0] pc;
    logic        v;
    logic [2:0]  fl;   // {ifid, idex, exmem}
    logic        tk;
  } vec_t;

  vec_t tbl[21];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic rst, logic stl, logic m, logic e, logic i,
                              logic [15:0] mt, logic [15:0] et, logic [15:0] it,
                              logic [15:0] pc, logic v, logic [2:0] fl, logic tk);
    vec_t r;
    r.rst = rst; r.stl = stl; r.m = m; r.e = e; r.i = i;
    r.mt = mt; r.et = et; r.it = it; r.pc = pc; r.v = v; r.fl = fl; r.tk = tk;
    return r;
  endfunction

  task automatic check(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stl, input logic m, input logic e, input logic i,
                       input logic [15:0] mt, input logic [15:0] et, input logic [15:0] it);
    reset = rst; stall = stl;
    mem_redirect = m; ex_redirect = e; id_redirect = i;
    mem_target = mt; ex_target = et; id_target = it;
  endtask

  task automatic check_all(input string tag, input int idx, input logic [15:0] pc, input logic v,
                           input logic [2:0] fl, input logic tk);
    logic [15:0] p1;
    p1 = pc + 16'd1;
    check({tag, ".pc_out"},   idx, pc_out, pc);
    check({tag, ".pc_plus1"}, idx, pc_plus1, p1);
    check({tag, ".if_valid"}, idx, {15'd0, if_valid}, {15'd0, v});
    check({tag, ".flush"},    idx, {13'd0, flush_ifid, flush_idex, flush_exmem}, {13'd0, fl});
    check({tag, ".taken"},    idx, {15'd0, redirect_taken}, {15'd0, tk});
  endtask

  // Reference model state: current fetch PC and whether fetch is valid.
  logic [15:0] m_pc;
  logic        m_v;

  initial begin
    // Directed table: expected outputs observed in the cycle the inputs are applied.
    tbl[0]  = mk(1,0,1,1,1, 16'h0100,16'h0200,16'h0300, 16'h0010,0,3'b000,0);
    tbl[1]  = mk(0,0,0,0,0, 0,0,0,                      16'h0010,0,3'b000,0);
    tbl[2]  = mk(0,0,0,0,0, 0,0,0,                      16'h0011,1,3'b000,0);
    tbl[3]  = mk(0,0,0,1,0, 0,16'h0040,0,               16'h0012,1,3'b110,1);
    tbl[4]  = mk(0,0,0,0,0, 0,0,0,                      16'h0040,0,3'b000,0);
    tbl[5]  = mk(0,0,1,1,1, 16'h0100,16'h0200,16'h0300, 16'h0041,1,3'b111,1);
    tbl[6]  = mk(0,0,0,0,1, 0,0,16'h0025,               16'h0100,0,3'b100,1);
    tbl[7]  = mk(0,1,0,0,0, 0,0,0,                      16'h0025,0,3'b000,0);
    tbl[8]  = mk(0,1,0,0,0, 0,0,0,                      16'h0025,1,3'b000,0);
    tbl[9]  = mk(0,1,0,0,0, 0,0,0,                      16'h0025,1,3'b000,0);
    tbl[10] = mk(0,1,0,0,1, 0,0,16'h0050,               16'h0025,1,3'b100,1);
    tbl[11] = mk(0,0,1,0,0, 16'hFFFF,0,0,               16'h0050,0,3'b111,1);
    tbl[12] = mk(0,0,0,0,0, 0,0,0,                      16'hFFFF,0,3'b000,0);
    tbl[13] = mk(0,0,0,0,0, 0,0,0,                      16'h0000,1,3'b000,0);
    tbl[14] = mk(0,0,0,1,0, 0,16'h0060,0,               16'h0001,1,3'b110,1);
    tbl[15] = mk(0,0,0,0,1, 0,0,16'h0060,               16'h0060,0,3'b100,1);
    tbl[16] = mk(1,0,0,1,0, 0,16'h0070,0,               16'h0060,0,3'b000,0);
    tbl[17] = mk(0,0,0,0,0, 0,0,0,                      16'h0010,0,3'b000,0);
    tbl[18] = mk(0,0,0,0,1, 0,0,16'h0011,               16'h0011,1,3'b100,1);
    tbl[19] = mk(0,0,0,0,0, 0,0,0,                      16'h0011,0,3'b000,0);
    tbl[20] = mk(0,0,0,0,0, 0,0,0,                      16'h0012,1,3'b000,0);

    drive(1,0,0,0,0, 0,0,0);
    repeat (2) @(posedge clk);

    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      drive(tbl[k].rst, tbl[k].stl, tbl[k].m, tbl[k].e, tbl[k].i, tbl[k].mt, tbl[k].et, tbl[k].it);
      #1;
      check_all("tbl", k, tbl[k].pc, tbl[k].v, tbl[k].fl, tbl[k].tk);
    end

    // Random phase: model continues from the state the table leaves behind.
    m_pc = 16'h0013;
    m_v  = 1'b1;
    for (int k = 0; k < 400; k++) begin
      logic rst, stl, m, e, i, tk;
      logic [15:0] mt, et, it, tgt;
      logic [2:0]  fl;
      rst = ($urandom_range(0, 39) == 0);
      stl = ($urandom_range(0, 3) == 0);
      m   = ($urandom_range(0, 7) == 0);
      e   = ($urandom_range(0, 5) == 0);
      i   = ($urandom_range(0, 4) == 0);
      mt  = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom);
      et  = 16'($urandom);
      it  = ($urandom_range(0, 5) == 0) ? m_pc : 16'($urandom);
      @(negedge clk);
      drive(rst, stl, m, e, i, mt, et, it);
      // Oldest-instruction-wins arbitration; nothing is accepted during reset.
      tk  = !rst && (m || e || i);
      tgt = m ? mt : (e ? et : it);
      fl  = rst ? 3'b000 : (m ? 3'b111 : (e ? 3'b110 : (i ? 3'b100 : 3'b000)));
      #1;
      check_all("rnd", k, m_pc, m_v, fl, tk);
      if (rst)       m_pc = RST_PC;
      else if (tk)   m_pc = tgt;
      else if (!stl) m_pc = m_pc + 16'd1;
      m_v = !(rst || tk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
